spawn_rng: RTL and testbench

Parametrised multi-channel pseudo-random spawn generator for falling objects (meteorites). A free-running maximal-length Fibonacci LFSR feeds a round-robin request/acknowledge server. Each served request gets a spawn X position in [0, X_MAX) and an X/Y speed pair. The block sits between the object controllers, one channel per object slot, and the frame-level game logic. It replaces the single-output position counter with per-slot handshaking, range-correct positions and selectable LFSR width.

---
 rtl/spawn_rng_if.sv | 16 +
 rtl/spawn_rng.sv | 135 +++++++++++++
 tb/tb_spawn_rng.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spawn_rng_if.sv
// Spawn request/acknowledge bundle between object slots and spawn_rng.
// master: object controllers raising req; slave: spawn_rng serving them.
interface spawn_rng_if #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 10,
    parameter int SPEED_W = 4
);
    logic [NUM_CH-1:0]  req;
    logic [NUM_CH-1:0]  ack;
    logic [WIDTH-1:0]   obj_x;
    logic [SPEED_W-1:0] x_speed;
    logic [SPEED_W-1:0] y_speed;

    modport master (output req, input ack, obj_x, x_speed, y_speed);
    modport slave  (input req, output ack, obj_x, x_speed, y_speed);
endinterface

// File: rtl/spawn_rng.sv
// Multi-channel LFSR spawn generator: round-robin grant, range-limited X position and speeds.
// Optional SPAWN_RNG_SEED_LOAD_EN adds seed_load/seed_data to reseed the LFSR at run time.
//
// state  | meaning
// IDLE   | waiting for any req; latches the round-robin winner
// SAMPLE | rejection-sampling the LFSR for a position below X_MAX
// DONE   | one-cycle ack to the latched channel, results valid
module spawn_rng #(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] TAPS      = 10'h240,
    parameter logic [WIDTH-1:0] SEED      = 10'h3FF,
    parameter int               NUM_CH    = 4,
    parameter int               X_MAX     = 640,
    parameter int               SPEED_W   = 4,
    parameter int               MAX_TRIES = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    spawn_rng_if.slave       bus,
    output logic [WIDTH-1:0] rng_state
`ifdef SPAWN_RNG_SEED_LOAD_EN
    ,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_data
`endif
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;
    localparam logic [WIDTH-1:0] XMAX_W   = WIDTH'(X_MAX);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;

    state_t             state_q, state_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [CH_W-1:0]    rr_q, rr_d, ch_q, ch_d;
    logic [WIDTH-1:0]   obj_x_q, obj_x_d;
    logic [SPEED_W-1:0] x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0]   lfsr;
    logic [CH_W-1:0]    pick, idx_c;
    logic               found;
    int                 idx;
    logic [SPEED_W-1:0] s_y;

    always_ff @(posedge Clk) begin
        if (!Reset_n)
            lfsr <= SEED;
`ifdef SPAWN_RNG_SEED_LOAD_EN
        else if (seed_load)
            lfsr <= (seed_data == '0) ? SEED : seed_data;
`endif
        else
            lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    end

    assign rng_state = lfsr;

    // First requesting channel at or after rr, wrapping around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        idx_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx   = (int'(rr_q) + i) % NUM_CH;
            idx_c = CH_W'(idx);
            if (!found && bus.req[idx_c]) begin
                pick  = idx_c;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            tries_q <= '0;
            rr_q    <= '0;
            ch_q    <= '0;
            obj_x_q <= '0;
            x_q     <= '0;
            y_q     <= SPEED_W'(1);
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            rr_q    <= rr_d;
            ch_q    <= ch_d;
            obj_x_q <= obj_x_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign s_y = lfsr[SPEED_W-1:0];

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        rr_d    = rr_q;
        ch_d    = ch_q;
        obj_x_d = obj_x_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    ch_d    = pick;
                    tries_d = '0;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (lfsr < XMAX_W || tries_q == TRY_LAST) begin
                    // Fallback subtraction stays in range because X_MAX >= 2^(WIDTH-1).
                    obj_x_d = (lfsr < XMAX_W) ? lfsr : lfsr - XMAX_W;
                    x_d     = lfsr[2*SPEED_W-1:SPEED_W];
                    y_d     = (s_y == '0) ? SPEED_W'(1) : s_y;
                    state_d = DONE;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            DONE: begin
                rr_d    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ack     = (state_q == DONE) ? (NUM_CH'(1) << ch_q) : '0;
    assign bus.obj_x   = obj_x_q;
    assign bus.x_speed = x_q;
    assign bus.y_speed = y_q;
endmodule

// File: tb/tb_spawn_rng.sv
// Randomized and directed bench for spawn_rng against a transaction-level reference model.
module tb_spawn_rng;
    localparam int          W       = 10;
    localparam logic [9:0]  TAPS    = 10'h240;
    localparam logic [9:0]  SEED    = 10'h3FF;
    localparam int          NUM_CH  = 4;
    localparam int          X_MAX   = 640;
    localparam int          SPEED_W = 4;
    localparam int          MAX_TRIES = 4;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic [W-1:0] rng_state;
`ifdef SPAWN_RNG_SEED_LOAD_EN
    logic seed_load = 1'b0;
    logic [W-1:0] seed_data = '0;
`endif

    spawn_rng_if #(.NUM_CH(NUM_CH), .WIDTH(W), .SPEED_W(SPEED_W)) bus ();

    spawn_rng #(
        .WIDTH(W), .TAPS(TAPS), .SEED(SEED), .NUM_CH(NUM_CH),
        .X_MAX(X_MAX), .SPEED_W(SPEED_W), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus),
        .rng_state(rng_state)
`ifdef SPAWN_RNG_SEED_LOAD_EN
        ,
        .seed_load(seed_load),
        .seed_data(seed_data)
`endif
    );

    always #5 Clk = ~Clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] nxt(input logic [W-1:0] s);
        return {s[W-2:0], 1'($countones(s & TAPS) % 2)};
    endfunction

    // Reference model: on each grant, the whole transaction outcome is
    // predicted from the future LFSR sequence and scheduled as one ack.
    int           cyc = 0;
    logic [W-1:0] m_lfsr = SEED;
    bit           m_busy = 1'b0;
    int           m_ack_edge = 0;
    int           m_ch = 0;
    int           m_rr = 0;
    int           p_obj = 0, p_xs = 0, p_ys = 1;
    int           e_ack = 0, e_obj = 0, e_xs = 0, e_ys = 1;

    always @(posedge Clk) begin
        logic [W-1:0] t;
        int k_hit;
        bit got;
        cyc++;
        e_ack = 0;
        if (!Reset_n) begin
            m_lfsr = SEED;
            m_busy = 1'b0;
            m_rr   = 0;
            e_obj  = 0; e_xs = 0; e_ys = 1;
        end else begin
`ifdef SPAWN_RNG_SEED_LOAD_EN
            if (seed_load) m_lfsr = (seed_data == 0) ? SEED : seed_data;
            else m_lfsr = nxt(m_lfsr);
`else
            m_lfsr = nxt(m_lfsr);
`endif
            if (!m_busy && bus.req != 0) begin
                got = 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!got && bus.req[(m_rr + i) % NUM_CH]) begin
                        m_ch = (m_rr + i) % NUM_CH;
                        got = 1'b1;
                    end
                end
                t = m_lfsr;
                got = 1'b0;
                k_hit = 0;
                for (int k = 0; k < MAX_TRIES; k++) begin
                    if (!got && (int'(t) < X_MAX || k == MAX_TRIES - 1)) begin
                        got = 1'b1;
                        k_hit = k;
                        p_obj = (int'(t) < X_MAX) ? int'(t) : int'(t) - X_MAX;
                        p_xs = (int'(t) / (1 << SPEED_W)) % (1 << SPEED_W);
                        p_ys = int'(t) % (1 << SPEED_W);
                        if (p_ys == 0) p_ys = 1;
                    end
                    if (!got) t = nxt(t);
                end
                m_ack_edge = cyc + 1 + k_hit;
                m_busy = 1'b1;
            end else if (m_busy && cyc == m_ack_edge) begin
                e_ack = 1 << m_ch;
                e_obj = p_obj; e_xs = p_xs; e_ys = p_ys;
                m_rr = (m_ch + 1) % NUM_CH;
            end else if (m_busy && cyc == m_ack_edge + 1) begin
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("cyc_ack", 32'(bus.ack), 32'(e_ack));
            check("cyc_rng", 32'(rng_state), 32'(m_lfsr));
            check("cyc_obj_x", 32'(bus.obj_x), 32'(e_obj));
            check("cyc_x_speed", 32'(bus.x_speed), 32'(e_xs));
            check("cyc_y_speed", 32'(bus.y_speed), 32'(e_ys));
        end
    end

    task automatic do_reset();
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic wait_ack(input int limit, output int n, output logic [NUM_CH-1:0] a);
        bit seen = 1'b0;
        n = 0;
        a = '0;
        while (!seen && n < limit) begin
            @(negedge Clk);
            n++;
            if (bus.ack != 0) begin
                a = bus.ack;
                seen = 1'b1;
            end
        end
    endtask

    logic [9:0] lfsr_exp [9] = '{10'h3FF, 10'h3FE, 10'h3FC, 10'h3F8, 10'h3F0,
                                 10'h3E0, 10'h3C0, 10'h380, 10'h301};

    initial begin
        int n, cnt, period;
        bit zero_seen;
        logic [NUM_CH-1:0] a, a_seen;
        bus.req = '0;
        @(negedge Clk);
        chk_en = 1'b1;

        // Free-run sequence right after reset
        do_reset();
        check("rst_ack", 32'(bus.ack), 32'h0);
        check("rst_obj_x", 32'(bus.obj_x), 32'h0);
        check("rst_x_speed", 32'(bus.x_speed), 32'h0);
        check("rst_y_speed", 32'(bus.y_speed), 32'h1);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge Clk);
            check("lfsr_seq", 32'(rng_state), 32'(lfsr_exp[i]));
        end

        // Period of the free-running LFSR
        do_reset();
        period = 0;
        zero_seen = 1'b0;
        do begin
            @(negedge Clk);
            period++;
            if (rng_state == 0) zero_seen = 1'b1;
        end while (rng_state != SEED && period < 2000);
        check("lfsr_period", 32'(period), 32'd1023);
        check("lfsr_no_zero", 32'(zero_seen), 32'd0);

        // Fallback on channel 0: samples 3FE,3FC,3F8,3F0 all >= 640
        do_reset();
        bus.req = 4'b0001;
        wait_ack(20, n, a);
        check("fb_latency", 32'(n), 32'd5);
        check("fb_ack", 32'(a), 32'h1);
        check("fb_obj_x", 32'(bus.obj_x), 32'd368);
        check("fb_x_speed", 32'(bus.x_speed), 32'hF);
        check("fb_y_speed", 32'(bus.y_speed), 32'h1);
        bus.req = '0;

        // Round-robin with all channels requesting
        do_reset();
        bus.req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_ack(20, n, a);
            check("rr_order", 32'(a), 32'(1 << (j % 4)));
            if (j > 0) check("rr_spacing", 32'(n >= 3), 32'd1);
            check("rr_obj_range", 32'(bus.obj_x < 10'(X_MAX)), 32'd1);
            check("rr_y_nonzero", 32'(bus.y_speed != 0), 32'd1);
        end
        bus.req = '0;
        repeat (10) @(negedge Clk);

        // One-cycle pulse cannot be cancelled
        bus.req = 4'b0100;
        @(negedge Clk);
        bus.req = '0;
        cnt = 0;
        a_seen = '0;
        repeat (20) begin
            @(negedge Clk);
            if (bus.ack != 0) begin
                cnt++;
                a_seen = bus.ack;
            end
        end
        check("cancel_count", 32'(cnt), 32'd1);
        check("cancel_ack", 32'(a_seen), 32'h4);

        // Reset while in SAMPLE aborts, held req is served afterwards
        bus.req = 4'b0001;
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        check("mid_rst_ack", 32'(bus.ack), 32'h0);
        check("mid_rst_rng", 32'(rng_state), 32'h3FF);
        check("mid_rst_obj_x", 32'(bus.obj_x), 32'h0);
        check("mid_rst_y", 32'(bus.y_speed), 32'h1);
        Reset_n = 1'b1;
        wait_ack(20, n, a);
        check("mid_rst_reserve", 32'(a), 32'h1);
        bus.req = '0;
        repeat (10) @(negedge Clk);

`ifdef SPAWN_RNG_SEED_LOAD_EN
        seed_load = 1'b1;
        seed_data = 10'h001;
        @(negedge Clk);
        check("seed_load_1", 32'(rng_state), 32'h001);
        seed_load = 1'b0;
        @(negedge Clk);
        check("seed_step", 32'(rng_state), 32'h002);
        seed_load = 1'b1;
        seed_data = 10'h000;
        @(negedge Clk);
        check("seed_load_0", 32'(rng_state), 32'h3FF);
        seed_load = 1'b0;
        @(negedge Clk);
`endif

        // Random traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            @(negedge Clk);
            if ($urandom_range(0, 5) == 0) bus.req = 4'($urandom_range(0, 15));
            Reset_n = ($urandom_range(0, 400) == 0) ? 1'b0 : 1'b1;
        end
        bus.req = '0;
        Reset_n = 1'b1;
        repeat (10) @(negedge Clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
